word_fetch_ctrl: RTL and testbench
==================================

Name: word_fetch_ctrl

Overview:
Upstream sequencer for shift_register32. It reads bytes from the 512-entry byte memory and drives the 32-bit shift register's write/shift strobes to pack four consecutive bytes into one word. It then presents the word to the downstream consumer with a valid/ready handshake. It repeats this for a programmed number of words starting at a programmed base address.

Parameters:
ADDR_W, 9, byte-memory address width (512 bytes)
CNT_W, 7, width of word_count (max 127 words per job)
BYTES_PER_WORD, 4, bytes packed per word; fixed to 4 for shift_register32

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle job start pulse; sampled only in IDLE
base_addr  input  ADDR_W  first byte address; captured on accepted start
word_count  input  CNT_W  number of words in the job; captured on accepted start
abort  input  1  synchronous job cancel; returns FSM to IDLE
mem_rd  output  1  byte-memory read strobe
mem_addr  output  ADDR_W  byte-memory address
mem_rdata  input  8  read data, valid exactly 1 cycle after mem_rd
sr_write  output  1  to shift_register32 write
sr_shift  output  1  to shift_register32 shift
sr_data  output  8  to shift_register32 data_in; equals mem_rdata
word_valid  output  1  shift_register32.data_out holds a complete word
word_ready  input  1  consumer accepts the word
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the last word is accepted

Behaviour:
- Reset: FSM=IDLE. All outputs 0. Internal addr, byte_idx and words_left are cleared.
- States: IDLE, READ, LOAD, SHIFT, PRESENT, FIN.
- IDLE:
  - On start, capture base_addr into addr and word_count into words_left. Clear byte_idx.
  - If word_count==0, go to FIN. Otherwise go to READ.
  - start is ignored outside IDLE.
- READ:
  - mem_rd=1, mem_addr=addr.
  - Next state is LOAD.
  - addr <= addr+1, wrapping modulo 2^ADDR_W (511 -> 0).
- LOAD:
  - sr_write=1, sr_data=mem_rdata.
  - If byte_idx==3, go to PRESENT. Otherwise go to SHIFT.
- SHIFT:
  - sr_shift=1.
  - byte_idx <= byte_idx+1.
  - Next state is READ.
- Per-word sequence: R L S R L S R L S R L, which is 11 cycles. PRESENT is asserted in the following cycle.
- Resulting word packing:
  - First byte lands in bits [31:24]; last byte lands in [7:0].
  - No clear is needed between words. The three shifts push out three old bytes, and the first write overwrites the fourth.
- PRESENT:
  - word_valid=1 and is held until word_ready=1. This state has no timeout.
  - When word_ready=1, words_left <= words_left-1 and byte_idx <= 0.
  - If words_left==1 on that handshake, go to FIN. Otherwise go to READ.
- FIN: done=1 for one cycle, then go to IDLE.
- sr_write and sr_shift are mutually exclusive, never both 1. mem_rd is asserted only in READ.
- mem_addr holds its last value when mem_rd=0. sr_data is a combinational pass-through of mem_rdata.
- abort:
  - In any non-IDLE state, the next state is IDLE. No done pulse. All strobes are 0 in the following cycle.
  - The shift register contents are left as-is.
- reset mid-job has the same effect as abort, and additionally clears all internal registers.
- If reset and abort are asserted together, reset wins. If abort and word_ready are asserted together in PRESENT, abort wins and the word is not counted.

Decomposition:
- Shared package (cad_ca3_pkg): ADDR_W=9, BYTES_PER_WORD=4, and the state enum typedef fetch_state_t {IDLE, READ, LOAD, SHIFT, PRESENT, FIN}.
- One sub-module: fetch_addr_counter. It is a loadable, wrapping ADDR_W-bit counter with load, inc and load_val inputs.
- The FSM and the words_left/byte_idx counters stay in word_fetch_ctrl.

Test Plan:
- Single word. Memory[16..19]=8'hA1,B2,C3,D4; base_addr=16, word_count=1, start, word_ready tied 1.
  - Required: word_valid rises 12 cycles after start, with shift_register32.data_out=32'hA1B2C3D4.
  - Required: done pulses the cycle after the handshake.
- Back-pressure over two words. Memory[0..7]=8'h01..08, word_count=2, word_ready held 0 for 5 cycles.
  - Required: word_valid stays 1 and the word stays 32'h01020304 throughout the stall.
  - Required: after word_ready, the second word is 32'h05060708, with no stale bytes.
- Address wrap. base_addr=510 over memory[510]=8'h11, [511]=8'h22, [0]=8'h33, [1]=8'h44.
  - Required: mem_addr sequence 510, 511, 0, 1 and word 32'h11223344.
- Zero-length job. word_count=0 with start.
  - Required: no mem_rd, sr_write or sr_shift is ever asserted.
  - Required: done pulses 1 cycle after start; busy is high for exactly 1 cycle.
- Abort mid-word. Assert abort during the second SHIFT of a word.
  - Required: next cycle is IDLE, with busy=0 and no done.
  - Required: a new start with base_addr=48 produces the correct word from memory[48..51].
- Reset in PRESENT. Assert reset while word_valid=1.
  - Required: all outputs 0 the next cycle, and start is accepted the cycle after reset is deasserted.
  - Required: start while busy has no effect, and the capture of base_addr is unchanged.

Source files
------------

// File: rtl/cad_ca3_pkg.sv
// Shared types and constants for the byte-to-word fetch sequencer.
package cad_ca3_pkg;

   localparam int ADDR_W         = 9;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      LOAD,
      SHIFT,
      PRESENT,
      FIN
   } fetch_state_t;

   // All registered control outputs of the sequencer, grouped so they can be
   // produced from a single state decode.
   typedef struct packed {
      logic mem_rd;
      logic sr_write;
      logic sr_shift;
      logic word_valid;
      logic busy;
      logic done;
   } strobe_t;

   // Output strobes that belong to a given state; loaded into the output
   // register together with the state itself.
   function automatic strobe_t strobes_of(input fetch_state_t s);
      strobe_t o;
      o            = '0;
      o.mem_rd     = (s == READ);
      o.sr_write   = (s == LOAD);
      o.sr_shift   = (s == SHIFT);
      o.word_valid = (s == PRESENT);
      o.busy       = (s != IDLE);
      o.done       = (s == FIN);
      return o;
   endfunction

endpackage

// File: rtl/fetch_addr_counter.sv
// Loadable byte address counter that wraps modulo 2^ADDR_W.
module fetch_addr_counter #(
   parameter int ADDR_W = cad_ca3_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] load_val,
   output logic [ADDR_W-1:0] count
);

   // Load has priority over increment; natural overflow gives the wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/word_fetch_ctrl.sv
// Sequencer that reads bytes from the byte memory and packs four of them into
// shift_register32, then offers each packed word downstream with valid/ready.
module word_fetch_ctrl #(
   parameter int ADDR_W         = cad_ca3_pkg::ADDR_W,
   parameter int CNT_W          = 7,
   parameter int BYTES_PER_WORD = cad_ca3_pkg::BYTES_PER_WORD
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              abort,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              sr_write,
   output logic              sr_shift,
   output logic [7:0]        sr_data,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              busy,
   output logic              done
);

   import cad_ca3_pkg::*;

   localparam int IDX_W = $clog2(BYTES_PER_WORD);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

   fetch_state_t      state;
   strobe_t           strb;
   logic [CNT_W-1:0]  words_left;
   logic [IDX_W-1:0]  byte_idx;
   logic [ADDR_W-1:0] addr;
   logic              addr_load;
   logic              addr_inc;

   // The counter holds the next byte to read; it is reloaded on an accepted
   // start and steps once per READ so that SHIFT/PRESENT see the next address.
   assign addr_load = (state == IDLE) && start;
   assign addr_inc  = (state == READ) && !abort;

   fetch_addr_counter #(
      .ADDR_W (ADDR_W)
   ) u_addr_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (addr_load),
      .inc      (addr_inc),
      .load_val (base_addr),
      .count    (addr)
   );

   assign mem_rd     = strb.mem_rd;
   assign sr_write   = strb.sr_write;
   assign sr_shift   = strb.sr_shift;
   assign word_valid = strb.word_valid;
   assign busy       = strb.busy;
   assign done       = strb.done;

   // Bytes go straight from the memory read port into the shift register.
   assign sr_data = mem_rdata;

   // Main FSM: state, registered strobes, read address and job counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         strb       <= '0;
         words_left <= '0;
         byte_idx   <= '0;
         mem_addr   <= '0;
      end else if (abort && (state != IDLE)) begin
         // Cancel without a done pulse; shift register contents are untouched.
         state <= IDLE;
         strb  <= strobes_of(IDLE);
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  words_left <= word_count;
                  byte_idx   <= '0;
                  if (word_count == '0) begin
                     state <= FIN;
                     strb  <= strobes_of(FIN);
                  end else begin
                     state    <= READ;
                     strb     <= strobes_of(READ);
                     mem_addr <= base_addr;
                  end
               end
            end
            READ: begin
               state <= LOAD;
               strb  <= strobes_of(LOAD);
            end
            LOAD: begin
               if (byte_idx == LAST_IDX) begin
                  state <= PRESENT;
                  strb  <= strobes_of(PRESENT);
               end else begin
                  state <= SHIFT;
                  strb  <= strobes_of(SHIFT);
               end
            end
            SHIFT: begin
               byte_idx <= byte_idx + 1'b1;
               state    <= READ;
               strb     <= strobes_of(READ);
               mem_addr <= addr;
            end
            PRESENT: begin
               if (word_ready) begin
                  words_left <= words_left - 1'b1;
                  byte_idx   <= '0;
                  if (words_left == CNT_W'(1)) begin
                     state <= FIN;
                     strb  <= strobes_of(FIN);
                  end else begin
                     state    <= READ;
                     strb     <= strobes_of(READ);
                     mem_addr <= addr;
                  end
               end
            end
            FIN: begin
               state <= IDLE;
               strb  <= strobes_of(IDLE);
            end
            default: begin
               state <= IDLE;
               strb  <= strobes_of(IDLE);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_word_fetch_ctrl.sv
// Scoreboard bench for word_fetch_ctrl with a byte memory and shift_register32 model.
module tb_word_fetch_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [8:0] base_addr;
   logic [6:0] word_count;
   logic       abort;
   logic       mem_rd;
   logic [8:0] mem_addr;
   logic [7:0] mem_rdata;
   logic       sr_write;
   logic       sr_shift;
   logic [7:0] sr_data;
   logic       word_valid;
   logic       word_ready;
   logic       busy;
   logic       done;

   logic [7:0]  mem [0:511];
   logic [31:0] sr;
   int          cyc = 0;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_addr [$];
   logic [31:0] exp_word [$];

   int rd_cnt = 0, wr_cnt = 0, sh_cnt = 0, busy_cnt = 0, done_cnt = 0;
   int done_cyc = -1, hs_cyc = -1;

   word_fetch_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .abort      (abort),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .sr_write   (sr_write),
      .sr_shift   (sr_shift),
      .sr_data    (sr_data),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Byte memory with one cycle read latency.
   always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

   // shift_register32: write replaces the low byte, shift moves bytes up by one.
   always @(posedge clk) begin
      if (sr_write)      sr <= {sr[31:8], sr_data};
      else if (sr_shift) sr <= {sr[23:0], 8'h00};
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Monitor: consumes scoreboard entries as the DUT reads bytes and hands off words.
   always @(negedge clk) begin
      logic [31:0] e;
      if (!reset) begin
         if (mem_rd) begin
            rd_cnt++;
            if (exp_addr.size() == 0) chk("addr_underflow", 32'd1, 32'd0);
            else begin
               e = exp_addr.pop_front();
               chk("mem_addr", 32'(mem_addr), e);
            end
         end
         if (sr_write) wr_cnt++;
         if (sr_shift) sh_cnt++;
         if (busy) busy_cnt++;
         if (sr_write && sr_shift) chk("strobe_excl", 32'd1, 32'd0);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (word_valid && word_ready) begin
            hs_cyc = cyc;
            if (exp_word.size() == 0) chk("word_underflow", 32'd1, 32'd0);
            else begin
               e = exp_word.pop_front();
               chk("word", sr, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int base, input int cnt, output int n);
      logic [31:0] w;
      int          a;
      n          = cyc;
      start      = 1'b1;
      base_addr  = 9'(base);
      word_count = 7'(cnt);
      for (int wi = 0; wi < cnt; wi++) begin
         w = '0;
         for (int b = 0; b < 4; b++) begin
            a = (base + wi * 4 + b) % 512;
            exp_addr.push_back(32'(a));
            w = {w[23:0], mem[a]};
         end
         exp_word.push_back(w);
      end
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (!word_valid && k < 60) begin
         tick();
         k++;
      end
      if (!word_valid) chk({tag, "_valid_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy && k < 300) begin
         tick();
         k++;
      end
      if (busy) chk({tag, "_idle_timeout"}, 32'd1, 32'd0);
      tick();
   endtask

   function automatic logic [31:0] outs();
      return {26'd0, mem_rd, sr_write, sr_shift, word_valid, busy, done};
   endfunction

   initial begin
      int n, d0, r0, w0, s0, b0;

      reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
      abort = 1'b0; word_ready = 1'b0; mem_rdata = '0; sr = '0;
      for (int i = 0; i < 512; i++) mem[i] = 8'((i * 7) ^ 8'h5A);
      mem[16] = 8'hA1; mem[17] = 8'hB2; mem[18] = 8'hC3; mem[19] = 8'hD4;
      for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
      mem[510] = 8'h11; mem[511] = 8'h22;
      mem[48] = 8'hDE; mem[49] = 8'hAD; mem[50] = 8'hBE; mem[51] = 8'hEF;

      // Reset state
      repeat (3) tick();
      chk("reset_outs", outs(), 32'd0);
      chk("reset_addr", 32'(mem_addr), 32'd0);
      reset = 1'b0;
      tick();

      // Single word with fixed latency and done timing
      word_ready = 1'b1;
      d0 = done_cnt;
      start_job(16, 1, n);
      wait_valid("single");
      chk("single_latency", 32'(cyc - n), 32'd12);
      wait_idle("single");
      chk("single_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("single_done_cyc", 32'(done_cyc - hs_cyc), 32'd1);

      // Back-pressure across two words
      word_ready = 1'b0;
      d0 = done_cnt;
      start_job(0, 2, n);
      wait_valid("stall");
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(word_valid), 32'd1);
         chk("stall_word", sr, 32'h01020304);
         tick();
      end
      word_ready = 1'b1;
      wait_idle("stall");
      chk("stall_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Address wrap 510,511,0,1 (mem[0],mem[1] hold 8'h01,8'h02 -> rewrite)
      mem[0] = 8'h33; mem[1] = 8'h44;
      start_job(510, 1, n);
      wait_idle("wrap");
      chk("wrap_addr_drained", 32'(exp_addr.size()), 32'd0);

      // Zero-length job
      r0 = rd_cnt; w0 = wr_cnt; s0 = sh_cnt; b0 = busy_cnt; d0 = done_cnt;
      start_job(100, 0, n);
      repeat (4) tick();
      chk("zero_rd", 32'(rd_cnt - r0), 32'd0);
      chk("zero_wr", 32'(wr_cnt - w0), 32'd0);
      chk("zero_sh", 32'(sh_cnt - s0), 32'd0);
      chk("zero_busy", 32'(busy_cnt - b0), 32'd1);
      chk("zero_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("zero_done_cyc", 32'(done_cyc - n), 32'd1);

      // Abort during the second SHIFT of a word
      d0 = done_cnt;
      start_job(32, 1, n);
      repeat (5) tick();
      chk("abort_in_shift", 32'(sr_shift), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_outs", outs(), 32'd0);
      tick();
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      exp_addr.delete();
      exp_word.delete();
      start_job(48, 1, n);
      wait_idle("after_abort");
      chk("after_abort_drained", 32'(exp_word.size()), 32'd0);

      // Reset while presenting a word, then restart and ignored start
      word_ready = 1'b0;
      start_job(64, 2, n);
      wait_valid("rst_present");
      reset = 1'b1;
      tick();
      chk("rst_outs", outs(), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      exp_addr.delete();
      exp_word.delete();
      reset = 1'b0;
      word_ready = 1'b1;
      d0 = done_cnt;
      start_job(80, 1, n);
      chk("rst_restart_busy", 32'(busy), 32'd1);
      repeat (2) tick();
      start = 1'b1; base_addr = 9'd200; word_count = 7'd5;
      tick();
      start = 1'b0;
      wait_idle("ignored_start");
      chk("ignored_done_cnt", 32'(done_cnt - d0), 32'd1);
      repeat (3) tick();
      chk("ignored_idle", 32'(busy), 32'd0);

      chk("final_addr_q", 32'(exp_addr.size()), 32'd0);
      chk("final_word_q", 32'(exp_word.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
